// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state encoding and the fixed div-by-zero quotient.
package mdu_seq_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Quotient returned for any division by zero, signed or unsigned.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Ops that occupy the unit for several cycles (everything but MTHI/MTLO).
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_arith.sv
// Combinational MDU datapath: produces the {HI,LO} result pair for one op,
// including the decided values for division by zero and signed overflow.
module mdu_seq_arith
  import mdu_seq_pkg::*;
(
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0]        a_sx, b_sx, a_zx, b_zx;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] a_s, b_s;
  logic signed [31:0] quot_s, rem_s;
  logic               div_ovf;

  // Sign/zero extension lets both multiplies be plain 64-bit products.
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign a_zx   = {32'd0, A};
  assign b_zx   = {32'd0, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign a_s     = A;
  assign b_s     = B;
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Signed divide truncates toward zero; remainder follows the dividend sign.
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    if (B != 32'd0 && !div_ovf) begin
      quot_s = a_s / b_s;
      rem_s  = a_s % b_s;
    end
  end

  // Select the result pair by op; zero divisor and overflow take fixed values.
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (Op)
      MDU_MULT:  {hi_res, lo_res} = prod_s;
      MDU_MULTU: {hi_res, lo_res} = prod_u;
      MDU_DIV: begin
        if (B == 32'd0) begin
          hi_res = A;
          lo_res = DIV0_QUOT;
        end else if (div_ovf) begin
          hi_res = 32'd0;
          lo_res = 32'h8000_0000;
        end else begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      MDU_DIVU: begin
        if (B == 32'd0) begin
          hi_res = A;
          lo_res = DIV0_QUOT;
        end else begin
          hi_res = A % B;
          lo_res = A / B;
        end
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// MDU sequencer: accepts one op from E stage, holds the result in a shadow
// pair for a fixed latency, then commits HI/LO together. Cancel from a
// flush abandons an op in flight without touching HI/LO.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      shadow_hi_q, shadow_lo_q;
  logic [31:0]      hi_d, lo_d;
  logic             accept;

  mdu_seq_arith u_arith (
    .Op     (Op),
    .A      (A),
    .B      (B),
    .hi_res (hi_d),
    .lo_res (lo_d)
  );

  // A flush in the same cycle drops the issuing op entirely.
  assign accept = Start && !Cancel;
  assign cnt_d  = cnt_q - 1'b1;

  // FSM, latency counter, shadow result and architectural HI/LO.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= MDU_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            if (is_long_op(Op)) begin
              shadow_hi_q <= hi_d;
              shadow_lo_q <= lo_d;
              cnt_q       <= (Op == MDU_DIV || Op == MDU_DIVU) ? DIV_LAST : MULT_LAST;
              state_q     <= MDU_BUSY;
              busy_q      <= 1'b1;
            end else if (Op == MDU_MTHI) begin
              hi_q <= A;
            end else if (Op == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        MDU_BUSY: begin
          // Cancel takes priority, even on the commit edge.
          if (Cancel) begin
            state_q     <= MDU_IDLE;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
          end else if (cnt_q == '0) begin
            hi_q    <= shadow_hi_q;
            lo_q    <= shadow_lo_q;
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases followed by random
// ops, all checked against a transaction-level model of HI/LO and Busy.
module tb_mdu_seq;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk, Rst_n, Start, Cancel;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi, m_lo;

  mdu_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Cancel (Cancel),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The hazard unit never issues into a busy unit; flag it if the bench does.
  always @(posedge Clk) begin
    if (Rst_n && Start && Busy) chk("start_while_busy", 64'd1, 64'd0);
  end

  // Reference {HI,LO} from the arithmetic definitions, via magnitudes for signed divide.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] ma, mb, q, r;
    logic [63:0] res;
    res = '0;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'(sa * sb);
      end
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          ma = a[31] ? (32'd0 - a) : a;
          mb = b[31] ? (32'd0 - b) : b;
          q  = ma / mb;
          r  = ma % mb;
          if (a[31] != b[31]) q = 32'd0 - q;
          if (a[31]) r = 32'd0 - r;
          res = {r, q};
        end
      end
      3'd3: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Issue one op and follow it to completion. cancel_at: -1 none,
  // -2 cancel together with Start, k>=0 cancel k cycles into BUSY.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input string tag);
    logic [63:0] r;
    int          n;
    bit          done;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; Cancel = (cancel_at == -2);
    @(negedge Clk);
    Start = 1'b0; Cancel = 1'b0;
    if (cancel_at == -2 || op >= 3'd4) begin
      if (cancel_at != -2) begin
        if (op == 3'd4) m_hi = a;
        else m_lo = a;
      end
      chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
      chk({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
      return;
    end
    r    = ref_res(op, a, b);
    n    = (op < 3'd2) ? MULT_N : DIV_N;
    done = 1'b0;
    for (int k = 0; k < n && !done; k++) begin
      chk({tag, "_busy_hi"}, {63'd0, Busy}, 64'd1);
      chk({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
      if (k == cancel_at) begin
        Cancel = 1'b1;
        @(negedge Clk);
        Cancel = 1'b0;
        chk({tag, "_cancel_busy"}, {63'd0, Busy}, 64'd0);
        chk({tag, "_cancel_hilo"}, {HI, LO}, {m_hi, m_lo});
        done = 1'b1;
      end else begin
        @(negedge Clk);
      end
    end
    if (!done) begin
      m_hi = r[63:32];
      m_lo = r[31:0];
      chk({tag, "_done_busy"}, {63'd0, Busy}, 64'd0);
      chk({tag, "_result"}, {HI, LO}, {m_hi, m_lo});
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          ca, n;

    Rst_n = 1'b0; Start = 1'b0; Cancel = 1'b0; Op = '0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    #3;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Directed cases.
    run_op(3'd4, 32'h0000_1234, 32'd0, -1, "mthi");
    chk("mthi_lo_kept", {32'd0, LO}, 64'd0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
    chk("mult_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1, "multu");
    chk("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
    chk("div_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd5, 32'd0, -1, "divu_zero");
    chk("divu_zero_const", {HI, LO}, 64'h0000_0005_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
    chk("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, -1, "div_zero");
    run_op(3'd5, 32'h1357_9BDF, 32'd0, -1, "mtlo");

    run_op(3'd4, 32'hAAAA_AAAA, 32'd0, -1, "set_hi");
    run_op(3'd5, 32'hAAAA_AAAA, 32'd0, -1, "set_lo");
    run_op(3'd2, 32'd100, 32'd7, 4, "div_cancel4");
    chk("cancel_const", {HI, LO}, 64'hAAAA_AAAA_AAAA_AAAA);
    run_op(3'd0, 32'd9, 32'd9, MULT_N - 1, "mult_cancel_commit");
    run_op(3'd3, 32'd77, 32'd3, DIV_N - 1, "divu_cancel_commit");
    run_op(3'd1, 32'd3, 32'd4, -2, "cancel_with_start");
    run_op(3'd4, 32'h5555_0000, 32'd0, -2, "cancel_with_mthi");
    chk("cancel_with_mthi_const", {32'd0, HI}, 64'h0000_0000_AAAA_AAAA);

    // Randomized ops with occasional corner operands and cancels.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 5));
        default: ;
      endcase
      n  = (op < 3'd2) ? MULT_N : DIV_N;
      ca = -1;
      case ($urandom_range(0, 7))
        0: ca = -2;
        1, 2: ca = $urandom_range(0, n - 1);
        default: ;
      endcase
      run_op(op, a, b, ca, "rand");
    end

    // Asynchronous reset in the middle of a multiply.
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, -1, "pre_rst_hi");
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, -1, "pre_rst_lo");
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd11; B = 32'd13;
    @(negedge Clk);
    Start = 1'b0;
    chk("mid_mult_busy", {63'd0, Busy}, 64'd1);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, Busy}, 64'd0);
    chk("async_rst_hilo", {HI, LO}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    run_op(3'd1, 32'd6, 32'd7, -1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
